// File: rtl/dmem_arb_pkg.sv
// Shared constants for the data-memory arbiter: FSM state codes, requester ids
// and the geometry of the attached data memory.
package dmem_arb_pkg;

  typedef logic [1:0] state_t;

  localparam state_t ST_IDLE   = 2'd0;
  localparam state_t ST_ACCESS = 2'd1;
  localparam state_t ST_RESP   = 2'd2;

  localparam logic REQ_ID_M0 = 1'b0;
  localparam logic REQ_ID_M1 = 1'b1;

  localparam int MEM_DEPTH  = 64;
  localparam int WORD_BYTES = 4;

endpackage

// File: rtl/dmem_arb_rr.sv
// Two-way round-robin pick: a lone request wins outright, a tie goes to the
// requester that was not granted last.
module dmem_arb_rr
  import dmem_arb_pkg::*;
(
  input  logic req0,
  input  logic req1,
  input  logic last_gnt,
  output logic winner
);

  // Winner selection
  always_comb begin
    winner = REQ_ID_M0;
    if (req0 && req1) begin
      winner = ~last_gnt;
    end else if (req1) begin
      winner = REQ_ID_M1;
    end else begin
      winner = REQ_ID_M0;
    end
  end

endmodule

// File: rtl/dmem_arbiter.sv
// Arbitrates two requesters onto one data memory with an IDLE/ACCESS/RESP cycle.
// Defining DMEM_ARB_ADDR_CHECK_EN rejects misaligned or out-of-range addresses.
module dmem_arbiter
  import dmem_arb_pkg::*;
#(
  parameter int ADDR_BUS_WIDTH = 32,
  parameter int DATA_BUS_WIDTH = 32
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      m0_req,
  input  logic                      m0_we,
  input  logic [ADDR_BUS_WIDTH-1:0] m0_addr,
  input  logic [DATA_BUS_WIDTH-1:0] m0_wdata,
  output logic                      m0_ack,
  output logic [DATA_BUS_WIDTH-1:0] m0_rdata,
  output logic                      m0_err,
  input  logic                      m1_req,
  input  logic                      m1_we,
  input  logic [ADDR_BUS_WIDTH-1:0] m1_addr,
  input  logic [DATA_BUS_WIDTH-1:0] m1_wdata,
  output logic                      m1_ack,
  output logic [DATA_BUS_WIDTH-1:0] m1_rdata,
  output logic                      m1_err,
  output logic [ADDR_BUS_WIDTH-1:0] mem_addr,
  output logic [DATA_BUS_WIDTH-1:0] mem_write_data,
  output logic                      mem_write_en,
  input  logic [DATA_BUS_WIDTH-1:0] mem_read_data
);

  state_t                    state_q, state_d;
  logic                      last_q, last_d;
  logic                      gnt_id_q, gnt_id_d;
  logic                      gnt_we_q, gnt_we_d;
  logic                      bad_q, bad_d;
  logic [ADDR_BUS_WIDTH-1:0] mem_addr_q, mem_addr_d;
  logic [DATA_BUS_WIDTH-1:0] mem_wdata_q, mem_wdata_d;
  logic                      mem_we_q, mem_we_d;
  logic                      m0_ack_q, m0_ack_d, m1_ack_q, m1_ack_d;
  logic                      m0_err_q, m0_err_d, m1_err_q, m1_err_d;
  logic [DATA_BUS_WIDTH-1:0] m0_rdata_q, m0_rdata_d, m1_rdata_q, m1_rdata_d;

  logic                      winner;
  logic                      any_req;
  logic                      sel_we;
  logic                      sel_bad;
  logic [ADDR_BUS_WIDTH-1:0] sel_addr;
  logic [DATA_BUS_WIDTH-1:0] sel_wdata;

  dmem_arb_rr u_rr (
    .req0     (m0_req),
    .req1     (m1_req),
    .last_gnt (last_q),
    .winner   (winner)
  );

  assign any_req   = m0_req | m1_req;
  assign sel_we    = (winner == REQ_ID_M1) ? m1_we    : m0_we;
  assign sel_addr  = (winner == REQ_ID_M1) ? m1_addr  : m0_addr;
  assign sel_wdata = (winner == REQ_ID_M1) ? m1_wdata : m0_wdata;

`ifdef DMEM_ARB_ADDR_CHECK_EN
  assign sel_bad = (sel_addr[1:0] != 2'b00) ||
                   (sel_addr > ADDR_BUS_WIDTH'(MEM_DEPTH - WORD_BYTES));
`else
  assign sel_bad = 1'b0;
`endif

  // Next-state and datapath; mem_* registers are only non-zero while in ACCESS
  always_comb begin
    state_d     = state_q;
    last_d      = last_q;
    gnt_id_d    = gnt_id_q;
    gnt_we_d    = gnt_we_q;
    bad_d       = bad_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    mem_we_d    = mem_we_q;
    m0_ack_d    = 1'b0;
    m1_ack_d    = 1'b0;
    m0_err_d    = 1'b0;
    m1_err_d    = 1'b0;
    m0_rdata_d  = m0_rdata_q;
    m1_rdata_d  = m1_rdata_q;
    case (state_q)
      ST_IDLE: begin
        if (any_req) begin
          state_d     = ST_ACCESS;
          last_d      = winner;
          gnt_id_d    = winner;
          gnt_we_d    = sel_we;
          bad_d       = sel_bad;
          mem_addr_d  = sel_addr;
          mem_wdata_d = sel_wdata;
          mem_we_d    = sel_we & ~sel_bad;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_ACCESS: begin
        state_d     = ST_RESP;
        mem_addr_d  = '0;
        mem_wdata_d = '0;
        mem_we_d    = 1'b0;
        if (gnt_id_q == REQ_ID_M1) begin
          m1_ack_d = 1'b1;
          m1_err_d = bad_q;
          if (bad_q) begin
            m1_rdata_d = '0;
          end else if (!gnt_we_q) begin
            m1_rdata_d = mem_read_data;
          end else begin
            m1_rdata_d = m1_rdata_q;
          end
        end else begin
          m0_ack_d = 1'b1;
          m0_err_d = bad_q;
          if (bad_q) begin
            m0_rdata_d = '0;
          end else if (!gnt_we_q) begin
            m0_rdata_d = mem_read_data;
          end else begin
            m0_rdata_d = m0_rdata_q;
          end
        end
      end
      ST_RESP: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d     = ST_IDLE;
        mem_addr_d  = '0;
        mem_wdata_d = '0;
        mem_we_d    = 1'b0;
      end
    endcase
  end

  // State registers; reset leaves requester 1 as last grant so requester 0 wins the first tie
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      last_q      <= REQ_ID_M1;
      gnt_id_q    <= REQ_ID_M0;
      gnt_we_q    <= 1'b0;
      bad_q       <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      mem_we_q    <= 1'b0;
      m0_ack_q    <= 1'b0;
      m1_ack_q    <= 1'b0;
      m0_err_q    <= 1'b0;
      m1_err_q    <= 1'b0;
      m0_rdata_q  <= '0;
      m1_rdata_q  <= '0;
    end else begin
      state_q     <= state_d;
      last_q      <= last_d;
      gnt_id_q    <= gnt_id_d;
      gnt_we_q    <= gnt_we_d;
      bad_q       <= bad_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      mem_we_q    <= mem_we_d;
      m0_ack_q    <= m0_ack_d;
      m1_ack_q    <= m1_ack_d;
      m0_err_q    <= m0_err_d;
      m1_err_q    <= m1_err_d;
      m0_rdata_q  <= m0_rdata_d;
      m1_rdata_q  <= m1_rdata_d;
    end
  end

  assign m0_ack         = m0_ack_q;
  assign m1_ack         = m1_ack_q;
  assign m0_err         = m0_err_q;
  assign m1_err         = m1_err_q;
  assign m0_rdata       = m0_rdata_q;
  assign m1_rdata       = m1_rdata_q;
  assign mem_addr       = mem_addr_q;
  assign mem_write_data = mem_wdata_q;
  assign mem_write_en   = mem_we_q;

endmodule
